// File: rtl/system_sequencer.sv
// Run controller for the ternary machine: load -> execute -> halt/timeout, and owner of the shared memory port.
// Latency: state changes one clock after the qualifying input; the memory mux is combinational from registered state and grant.
// Backpressure: none; the debug master waits for dbg_gnt, and SYS_AUTO_RESTART_EN optionally enables auto-restart from HALTED.
module system_sequencer #(
    parameter int WORD_SIZE     = 9,
    parameter int MEM_ADDR_SIZE = 6,
    parameter int CYCLE_CNT_W   = 24,
    parameter int MAX_CYCLES    = 0,
    parameter int RESTART_DELAY = 4   // must be >= 1 when auto-restart is built
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    output logic                       ldr_start,
    input  logic                       ldr_done,
    input  logic [2*MEM_ADDR_SIZE-1:0] ldr_addr,
    input  logic [2*WORD_SIZE-1:0]     ldr_wdata,
    input  logic                       ldr_we,
    output logic                       cpu_execute,
    input  logic                       cpu_halted,
    input  logic [2*MEM_ADDR_SIZE-1:0] cpu_addr,
    input  logic [2*WORD_SIZE-1:0]     cpu_wdata,
    input  logic                       cpu_we,
    input  logic                       cpu_re,
    input  logic                       dbg_req,
    output logic                       dbg_gnt,
    input  logic [2*MEM_ADDR_SIZE-1:0] dbg_addr,
    input  logic [2*WORD_SIZE-1:0]     dbg_wdata,
    input  logic                       dbg_we,
    input  logic                       dbg_re,
    output logic [2*MEM_ADDR_SIZE-1:0] mem_addr,
    output logic [2*WORD_SIZE-1:0]     mem_wdata,
    output logic                       mem_we,
    output logic                       mem_re,
    output logic [2:0]                 sys_state,
    output logic [CYCLE_CNT_W-1:0]     cycle_count,
    output logic                       timeout,
    output logic [7:0]                 run_count
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOADING   = 3'd1,
        ST_EXECUTING = 3'd2,
        ST_HALTED    = 3'd3,
        ST_TIMEOUT   = 3'd4
    } state_t;

    // Last EXECUTING count value before the watchdog trips (unused when MAX_CYCLES is 0).
    localparam logic [CYCLE_CNT_W-1:0] LP_WD_LAST =
        CYCLE_CNT_W'((MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1);

    state_t                   r_state;
    state_t                   w_next_state;
    logic                     r_start_q;
    logic                     r_dbg_gnt;
    logic [CYCLE_CNT_W-1:0]   r_cycle_count;
    logic                     r_timeout;
    logic [7:0]               r_run_count;

    logic                     w_start_edge;
    logic                     w_wd_hit;
    logic                     w_idle_like;
    logic                     w_load;      // entering LOADING this edge
    logic                     w_halt;      // run completed this edge
    logic                     w_wd_fire;   // watchdog expiry this edge
    logic                     w_restart;   // auto-restart into EXECUTING this edge
    logic                     w_restart_due;

    // Starts are suppressed while the debug master asks for the port.
    assign w_start_edge = start & ~r_start_q & ~dbg_req;
    assign w_wd_hit     = (MAX_CYCLES != 0) && (r_cycle_count == LP_WD_LAST);
    assign w_idle_like  = (r_state == ST_IDLE) || (r_state == ST_HALTED) || (r_state == ST_TIMEOUT);

`ifdef SYS_AUTO_RESTART_EN
    localparam int RC_W = $clog2(RESTART_DELAY + 1);
    logic [RC_W-1:0] r_restart_cnt;

    assign w_restart_due = (r_state == ST_HALTED) && !dbg_req &&
                           (r_restart_cnt == RC_W'(RESTART_DELAY - 1));

    // Count consecutive HALTED cycles with no debug request; any request restarts the wait.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_restart_cnt <= '0;
        else if ((r_state == ST_HALTED) && !dbg_req && !w_restart_due)
            r_restart_cnt <= r_restart_cnt + 1'b1;
        else
            r_restart_cnt <= '0;
    end
`else
    assign w_restart_due = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    // Next-state logic, transition strobes and run enables; abort outranks everything in LOADING/EXECUTING.
    always_comb begin
        w_next_state = ST_IDLE;
        w_load       = 1'b0;
        w_halt       = 1'b0;
        w_wd_fire    = 1'b0;
        w_restart    = 1'b0;
        ldr_start    = 1'b0;
        cpu_execute  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) begin
                    w_next_state = ST_LOADING;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LOADING: begin
                ldr_start = 1'b1;
                if (abort)
                    w_next_state = ST_IDLE;
                else if (ldr_done)
                    w_next_state = ST_EXECUTING;
                else
                    w_next_state = ST_LOADING;
            end
            ST_EXECUTING: begin
                cpu_execute = 1'b1;
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (cpu_halted) begin
                    w_next_state = ST_HALTED;
                    w_halt       = 1'b1;
                end else if (w_wd_hit) begin
                    w_next_state = ST_TIMEOUT;
                    w_wd_fire    = 1'b1;
                end else begin
                    w_next_state = ST_EXECUTING;
                end
            end
            ST_HALTED: begin
                if (w_start_edge) begin
                    w_next_state = ST_LOADING;
                    w_load       = 1'b1;
                end else if (w_restart_due) begin
                    w_next_state = ST_EXECUTING;
                    w_restart    = 1'b1;
                end else begin
                    w_next_state = ST_HALTED;
                end
            end
            ST_TIMEOUT: begin
                if (w_start_edge) begin
                    w_next_state = ST_LOADING;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = ST_TIMEOUT;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Start edge history and debug grant; grant only follows a request seen in a port-free state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_start_q <= 1'b0;
            r_dbg_gnt <= 1'b0;
        end else begin
            r_start_q <= start;
            r_dbg_gnt <= dbg_req && w_idle_like;
        end
    end

    // Run bookkeeping: saturating EXECUTING cycle counter, sticky timeout flag, wrapping run counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
            r_run_count   <= '0;
        end else begin
            if (w_load || w_restart)
                r_cycle_count <= '0;
            else if ((r_state == ST_EXECUTING) && (r_cycle_count != {CYCLE_CNT_W{1'b1}}))
                r_cycle_count <= r_cycle_count + 1'b1;

            if (w_load)
                r_timeout <= 1'b0;
            else if (w_wd_fire)
                r_timeout <= 1'b1;

            if (w_halt)
                r_run_count <= r_run_count + 8'd1;
        end
    end

    // Memory port mux; debug traffic is only forwarded in states where the grant is legal.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (r_state == ST_LOADING) begin
            mem_addr  = ldr_addr;
            mem_wdata = ldr_wdata;
            mem_we    = ldr_we;
        end else if (r_state == ST_EXECUTING) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
            mem_re    = cpu_re;
        end else if (r_dbg_gnt && w_idle_like) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_we    = dbg_we;
            mem_re    = dbg_re;
        end
    end

    assign dbg_gnt     = r_dbg_gnt;
    assign sys_state   = r_state;
    assign cycle_count = r_cycle_count;
    assign timeout     = r_timeout;
    assign run_count   = r_run_count;

endmodule

// File: tb/tb_system_sequencer.sv
// Bench for system_sequencer: state transitions are scoreboarded, port/handshake behaviour checked directly.
// Watchdog limit is set to 12 so a 10-cycle run halts normally and a non-halting run times out.
// All waits are fixed cycle counts, so the run always ends.
module tb_system_sequencer;

    localparam int AW = 12;
    localparam int DW = 18;

    logic          clock;
    logic          reset;
    logic          start, abort;
    logic          ldr_start, ldr_done, ldr_we;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic          cpu_execute, cpu_halted, cpu_we, cpu_re;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          dbg_req, dbg_gnt, dbg_we, dbg_re;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we, mem_re;
    logic [2:0]    sys_state;
    logic [23:0]   cycle_count;
    logic          timeout;
    logic [7:0]    run_count;

    system_sequencer #(
        .WORD_SIZE(9), .MEM_ADDR_SIZE(6), .CYCLE_CNT_W(24), .MAX_CYCLES(12), .RESTART_DELAY(4)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .ldr_start(ldr_start), .ldr_done(ldr_done),
        .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_we(ldr_we),
        .cpu_execute(cpu_execute), .cpu_halted(cpu_halted),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .dbg_req(dbg_req), .dbg_gnt(dbg_gnt),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_we(dbg_we), .dbg_re(dbg_re),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .sys_state(sys_state), .cycle_count(cycle_count), .timeout(timeout), .run_count(run_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  st;
        logic [23:0] cc;
        logic [7:0]  rc;
        logic        to;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic expect_state(input logic [2:0] st, input int cc, input int rc, input logic to);
        exp_t e;
        e.st = st;
        e.cc = 24'(cc);
        e.rc = 8'(rc);
        e.to = to;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_mem(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic we, input logic re);
        chk({tag, "_addr"},  32'(mem_addr),  32'(a));
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'(d));
        chk({tag, "_we"},    32'(mem_we),    32'(we));
        chk({tag, "_re"},    32'(mem_re),    32'(re));
    endtask

    // Halted is raised during the n-th EXECUTING cycle after ldr_done is accepted.
    task automatic run_exec(input int n);
        ldr_done = 1'b1;
        tick();
        ldr_done = 1'b0;
        repeat (n - 1) tick();
        cpu_halted = 1'b1;
        tick();
        cpu_halted = 1'b0;
    endtask

    // Scoreboard monitor: every observed state change must match the next queued expectation.
    initial begin
        logic [2:0] prev;
        exp_t       e;
        prev = 3'd0;
        forever begin
            @(negedge clock);
            if (!reset && sys_state !== prev) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_transition", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_state",       32'(sys_state),   32'(e.st));
                    chk("sb_cycle_count", 32'(cycle_count), 32'(e.cc));
                    chk("sb_run_count",   32'(run_count),   32'(e.rc));
                    chk("sb_timeout",     32'(timeout),     32'(e.to));
                    chk("sb_cpu_execute", 32'(cpu_execute), 32'(e.st == 3'd2));
                    chk("sb_ldr_start",   32'(ldr_start),   32'(e.st == 3'd1));
                end
                prev = sys_state;
            end
        end
    end

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        ldr_done = 1'b0; ldr_addr = '0; ldr_wdata = '0; ldr_we = 1'b0;
        cpu_halted = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_re = 1'b0;
        dbg_req = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_we = 1'b0; dbg_re = 1'b0;
        #2 reset = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_state",   32'(sys_state),   32'd0);
        chk("rst_cycles",  32'(cycle_count), 32'd0);
        chk("rst_runs",    32'(run_count),   32'd0);
        chk("rst_timeout", 32'(timeout),     32'd0);
        chk("rst_gnt",     32'(dbg_gnt),     32'd0);
        chk("rst_ldr",     32'(ldr_start),   32'd0);
        chk("rst_exec",    32'(cpu_execute), 32'd0);
        chk_mem("rst_mem", '0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();

        // Normal run: load, 10 EXECUTING cycles, halt; debug request held off during execution
        ldr_addr = 12'h0A5; ldr_wdata = 18'h2_1234; ldr_we = 1'b1;
        cpu_addr = 12'h3C1; cpu_wdata = 18'h1_0F0F; cpu_we = 1'b0; cpu_re = 1'b1;
        dbg_addr = 12'h111; dbg_wdata = 18'h0_2222; dbg_we = 1'b1; dbg_re = 1'b1;
        start = 1'b1;
        expect_state(3'd1, 0, 0, 1'b0);
        tick();
        start = 1'b0;
        chk_mem("mem_ldr", 12'h0A5, 18'h2_1234, 1'b1, 1'b0);
        repeat (3) tick();
        expect_state(3'd2, 0, 0, 1'b0);
        ldr_done = 1'b1;
        tick();
        ldr_done = 1'b0;
        chk_mem("mem_cpu", 12'h3C1, 18'h1_0F0F, 1'b0, 1'b1);
        dbg_req = 1'b1;
        repeat (9) tick();
        chk("gnt_in_exec", 32'(dbg_gnt), 32'd0);
        chk_mem("mem_cpu_dbgreq", 12'h3C1, 18'h1_0F0F, 1'b0, 1'b1);
        cpu_halted = 1'b1;
        expect_state(3'd3, 10, 1, 1'b0);
        tick();
        cpu_halted = 1'b0;
        chk("gnt_first_halt_cycle", 32'(dbg_gnt), 32'd0);
        chk_mem("mem_idle_nogrant", '0, '0, 1'b0, 1'b0);
        tick();
        chk("gnt_after_halt", 32'(dbg_gnt), 32'd1);
        chk_mem("mem_dbg", 12'h111, 18'h0_2222, 1'b1, 1'b1);
        start = 1'b1;
        tick();
        tick();
        chk("start_ignored_dbg", 32'(sys_state), 32'd3);
        start = 1'b0;
        tick();
        dbg_req = 1'b0;
        tick();
        chk("gnt_fall", 32'(dbg_gnt), 32'd0);
        chk("mem_we_after_gnt", 32'(mem_we), 32'd0);

        // Watchdog: CPU never halts, expiry after exactly 12 EXECUTING cycles
        start = 1'b1;
        expect_state(3'd1, 0, 1, 1'b0);
        tick();
        start = 1'b0;
        expect_state(3'd2, 0, 1, 1'b0);
        ldr_done = 1'b1;
        tick();
        ldr_done = 1'b0;
        expect_state(3'd4, 12, 1, 1'b1);
        repeat (14) tick();
        chk("to_state",   32'(sys_state),   32'd4);
        chk("to_flag",    32'(timeout),     32'd1);
        chk("to_exec",    32'(cpu_execute), 32'd0);
        chk("to_cycles",  32'(cycle_count), 32'd12);
        start = 1'b1;
        expect_state(3'd1, 0, 1, 1'b0);
        tick();
        start = 1'b0;
        chk("to_cleared", 32'(timeout), 32'd0);

        // Halt and watchdog expiry in the same cycle: halt wins
        expect_state(3'd2, 0, 1, 1'b0);
        expect_state(3'd3, 12, 2, 1'b0);
        run_exec(12);
        chk("tie_state",   32'(sys_state), 32'd3);
        chk("tie_timeout", 32'(timeout),   32'd0);
        tick();

        // Abort during LOADING
        start = 1'b1;
        expect_state(3'd1, 0, 2, 1'b0);
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1;
        expect_state(3'd0, 0, 2, 1'b0);
        tick();
        abort = 1'b0;
        chk("abort_state", 32'(sys_state), 32'd0);
        chk("abort_ldr",   32'(ldr_start), 32'd0);
        chk_mem("abort_mem", '0, '0, 1'b0, 1'b0);
        tick();

        // Asynchronous reset in the middle of EXECUTING
        start = 1'b1;
        expect_state(3'd1, 0, 2, 1'b0);
        tick();
        start = 1'b0;
        expect_state(3'd2, 0, 2, 1'b0);
        ldr_done = 1'b1;
        tick();
        ldr_done = 1'b0;
        repeat (3) tick();
        chk("pre_rst_exec", 32'(cpu_execute), 32'd1);
        expect_state(3'd0, 0, 0, 1'b0);
        #3 reset = 1'b1;
        #1;
        chk("arst_state",  32'(sys_state),   32'd0);
        chk("arst_exec",   32'(cpu_execute), 32'd0);
        chk("arst_cycles", 32'(cycle_count), 32'd0);
        chk("arst_runs",   32'(run_count),   32'd0);
        chk("arst_mem_re", 32'(mem_re),      32'd0);
        tick();
        reset = 1'b0;
        repeat (3) tick();

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
